// File: rtl/kyber_encode_pkg.sv
// kyber_encode_pkg: shared constants, FSM states and length helper for ByteEncode_d streaming
package kyber_encode_pkg;
    localparam int N        = 256;
    localparam int MAX_D    = 12;
    localparam int MAX_POLY = 4;
    localparam int D_T      = 12;
    localparam int D_U      = 10;
    localparam int D_V      = 4;
    localparam int D_M      = 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int bytes_per_poly(input int d);
        return 32 * d;
    endfunction
endpackage

// File: rtl/bit_packer.sv
// bit_packer: LSB-first accumulator that shifts in d-bit coefficients and shifts out bytes
module bit_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_in,
    input  logic        shift_out,
    input  logic [3:0]  d,
    input  logic [15:0] coef,
    output logic [7:0]  byte_out,
    output logic [4:0]  bits
);
    logic [23:0] acc;
    logic [15:0] masked;
    assign masked   = coef & ~(16'hffff << d);
    assign byte_out = acc[7:0];
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc  <= '0;
            bits <= '0;
        end else if (shift_in) begin
            acc  <= acc | (24'(masked) << bits);
            bits <= bits + 5'(d);
        end else if (shift_out) begin
            acc  <= acc >> 8;
            bits <= bits - 5'd8;
        end
    end
endmodule

// File: rtl/encode_stream_ctrl.sv
// encode_stream_ctrl: job FSM, counters and handshakes around bit_packer for ByteEncode_d streams
module encode_stream_ctrl
    import kyber_encode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  d_sel,
    input  logic [2:0]  n_poly,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        coef_valid,
    input  logic [15:0] coef,
    output logic        coef_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    input  logic        byte_ready,
    output logic [1:0]  poly_idx
);
    state_t      state, state_n;
    logic [3:0]  d_r;
    logic [2:0]  np_r, poly_cnt;
    logic [7:0]  coef_cnt;
    logic [4:0]  bits;
    logic        legal, accept, coef_hs, byte_hs, last;
    assign legal      = d_sel != 4'd0 && d_sel <= 4'(MAX_D) && n_poly != 3'd0 && n_poly <= 3'(MAX_POLY);
    assign accept     = state == IDLE && start && legal;
    assign coef_ready = state == RUN && bits < 5'd8 && poly_cnt != np_r;
    assign byte_valid = state == RUN && bits >= 5'd8;
    assign coef_hs    = coef_valid && coef_ready;
    assign byte_hs    = byte_valid && byte_ready;
    // 256*d is a multiple of 8, so the byte that empties the packer after the last coefficient ends the job
    assign last       = byte_hs && bits == 5'd8 && poly_cnt == np_r;
    assign busy       = state == RUN;
    assign done       = state == DONE;
    assign poly_idx   = poly_cnt[1:0];
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = IDLE;
        state_n = state == IDLE ? (accept ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r      <= '0;
            np_r     <= '0;
            coef_cnt <= '0;
            poly_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= state == IDLE && start && !legal;
            if (accept) begin
                d_r      <= d_sel;
                np_r     <= n_poly;
                coef_cnt <= '0;
                poly_cnt <= '0;
            end else if (state == DONE) begin
                poly_cnt <= '0;
            end else if (coef_hs) begin
                coef_cnt <= coef_cnt + 8'd1;
                if (coef_cnt == 8'd255) poly_cnt <= poly_cnt + 3'd1;
            end
        end
    end
    bit_packer u_pack (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .shift_in  (coef_hs),
        .shift_out (byte_hs),
        .d         (d_r),
        .coef      (coef),
        .byte_out  (byte_out),
        .bits      (bits)
    );
endmodule

// File: tb/tb_encode_stream_ctrl.sv
// tb_encode_stream_ctrl: drives encode jobs and compares bytes against a bit-stream model
module tb_encode_stream_ctrl;
    import kyber_encode_pkg::*;
    logic        clk = 0, rst = 1, start = 0, coef_valid = 0, byte_ready = 0;
    logic [3:0]  d_sel = 0;
    logic [2:0]  n_poly = 0;
    logic [15:0] coef = 0;
    logic        busy, done, err, coef_ready, byte_valid;
    logic [7:0]  byte_out;
    logic [1:0]  poly_idx;
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] cf [4*N];
    logic [7:0]  exp_q [$];
    typedef struct {logic [3:0] d; logic [2:0] np; logic e; logic b;} sv_t;
    sv_t tv [7];

    encode_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .d_sel(d_sel), .n_poly(n_poly),
        .busy(busy), .done(done), .err(err), .coef_valid(coef_valid), .coef(coef),
        .coef_ready(coef_ready), .byte_valid(byte_valid), .byte_out(byte_out),
        .byte_ready(byte_ready), .poly_idx(poly_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: lay out the stream bit by bit, then cut it into bytes
    task automatic build(input int d, input int total);
        bit sb [$];
        logic [7:0] b;
        exp_q.delete();
        for (int k = 0; k < total; k++)
            for (int j = 0; j < d; j++) sb.push_back(cf[k][j]);
        for (int k = 0; k < sb.size() / 8; k++) begin
            for (int j = 0; j < 8; j++) b[j] = sb[8*k+j];
            exp_q.push_back(b);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_coef_ready", coef_ready, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_poly_idx", poly_idx, 0);
    endtask

    task automatic run_job(input int d, input int np, input int mode, input int rpct,
                           input int vpct, input int stop_at, input bit poke);
        int total, nb, ci, bo, cyc;
        bit fin, pv, pr;
        logic [7:0] pb;
        total = np * N;
        for (int k = 0; k < total; k++) begin
            case (mode)
                0: cf[k] = 16'(k % N) & 16'hf;
                1: cf[k] = k == 0 ? 16'h0abc : k == 1 ? 16'h0123 : 16'h0;
                2: cf[k] = 16'hffff;
                3: cf[k] = 16'(k & 1);
                default: cf[k] = 16'($urandom);
            endcase
        end
        build(d, total);
        nb = exp_q.size();
        start  = 1;
        d_sel  = 4'(d);
        n_poly = 3'(np);
        @(negedge clk);
        start = 0;
        {ci, bo, cyc, fin, pv, pr, pb} = '0;
        while (1) begin
            if (fin) begin
                chk("done", done, 1);
                chk("busy_end", busy, 0);
                @(negedge clk);
                chk("done_pulse", done, 0);
                break;
            end
            if (bo == stop_at) break;
            if (cyc == 20000) begin
                chk("timeout_bytes", bo, nb);
                break;
            end
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("poly_idx", poly_idx, (ci / N) % 4);
            chk("excl", byte_valid && coef_ready, 0);
            if (pv && !pr) begin
                chk("hold_valid", byte_valid, 1);
                chk("hold_byte", byte_out, int'(pb));
            end
            start      = poke && cyc == 10;
            d_sel      = 4'd1;
            n_poly     = 3'd1;
            byte_ready = $urandom_range(99) < rpct;
            coef_valid = ci < total && $urandom_range(99) < vpct;
            coef       = coef_valid ? cf[ci] : 16'($urandom);
            if (byte_valid && byte_ready) begin
                chk($sformatf("byte%0d", bo), byte_out, int'(exp_q[bo]));
                bo++;
                fin = bo == nb;
            end
            if (coef_valid && coef_ready) ci++;
            pv = byte_valid;
            pr = byte_ready;
            pb = byte_out;
            cyc++;
            @(negedge clk);
        end
        start      = 0;
        coef_valid = 0;
        byte_ready = 0;
    endtask

    initial begin
        tv[0] = '{4'd0,  3'd1, 1'b1, 1'b0};
        tv[1] = '{4'd13, 3'd1, 1'b1, 1'b0};
        tv[2] = '{4'd1,  3'd0, 1'b1, 1'b0};
        tv[3] = '{4'd15, 3'd4, 1'b1, 1'b0};
        tv[4] = '{4'd12, 3'd5, 1'b1, 1'b0};
        tv[5] = '{4'd5,  3'd7, 1'b1, 1'b0};
        tv[6] = '{4'd12, 3'd4, 1'b0, 1'b1};
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 0;
        @(negedge clk);
        foreach (tv[i]) begin
            start  = 1;
            d_sel  = tv[i].d;
            n_poly = tv[i].np;
            @(negedge clk);
            start = 0;
            chk($sformatf("err_tv%0d", i), err, tv[i].e);
            chk($sformatf("busy_tv%0d", i), busy, tv[i].b);
            @(negedge clk);
            chk($sformatf("err_pulse_tv%0d", i), err, 0);
            if (tv[i].b) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                @(negedge clk);
            end
        end
        run_job(4, 1, 0, 100, 100, -1, 0);
        chk("idle_poly_idx", poly_idx, 0);
        run_job(12, 1, 1, 100, 100, -1, 1);
        run_job(10, 3, 2, 100, 100, -1, 0);
        run_job(1, 1, 3, 30, 100, -1, 0);
        run_job(int'($urandom_range(12, 1)), int'($urandom_range(2, 1)), 4, 50, 70, -1, 0);
        run_job(10, 1, 4, 80, 90, 100, 0);
        rst = 1;
        @(negedge clk);
        check_reset_vals();
        rst = 0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_job(4, 1, 0, 100, 100, -1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
